priority_grant_encoder: RTL and testbench
=========================================

# priority_grant_encoder

Parametrised, registered priority encoder with a valid/ready output handshake and optional round-robin fairness. It takes N request lines (idle-iterator flags from the fractal compute array), selects one winner, and presents its binary index and one-hot grant to a downstream dispatcher. The grant is held until accepted. It supersedes the purely combinational 10-bit encoder wherever a stable, fair, back-pressured selection is needed.

## Interface
- N, 10: number of request lines; N ≥ 2.
- IDX_W, 4: width of out_idx; must satisfy 2^IDX_W ≥ N.
- ROUND_ROBIN, 0: 0 = fixed priority (highest index wins); 1 = rotating priority.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  request vector; bit i high = requester i wants a grant.
- out_valid  out  1  a winner is being presented.
- out_ready  in  1  downstream accepts the winner; handshake = out_valid & out_ready.
- out_idx  out  IDX_W  binary index of the winner.
- out_onehot  out  N  one-hot grant, equal to 1 << out_idx when out_valid; all zero otherwise.

## Operation
- Two states:
  - IDLE: out_valid = 0.
  - HOLD: out_valid = 1.
- Pointer ptr (IDX_W bits, range 0..N-1) sets the search start.
  - Search from ptr downward: ptr, ptr-1, …, 0, then N-1, …, ptr+1.
  - The first set bit of the search vector wins.
- Fixed mode: ptr is constant N-1, so the highest set index wins.
- Round-robin mode: on every handshake with winner g, ptr ← (g == 0) ? N-1 : g-1.
- IDLE → HOLD: when req ≠ 0, latch the winner from req. No change while req = 0.
- HOLD, no handshake:
  - out_idx, out_onehot and ptr are frozen, regardless of req.
  - The grant is sticky: it stays presented even if the granted req bit drops or a higher-priority bit rises.
- HOLD with handshake:
  - Compute the search vector v = req & ~out_onehot, which excludes the just-granted requester for this cycle only.
  - If v ≠ 0: latch the new winner from v using the updated ptr and stay in HOLD. This gives back-to-back grants at one per cycle.
  - If v = 0: go to IDLE, with out_valid = 0 and out_onehot = 0. out_idx keeps its last value.
- out_ready while IDLE is ignored.
- Unused encodings (out_idx ≥ N) are never produced.

## Timing
- Reset, asynchronous on rst_n low, applies regardless of clk:
  - state = IDLE, out_valid = 0, out_idx = 0, out_onehot = 0, ptr = N-1.
  - Reset mid-HOLD drops the pending grant with no handshake. Round-robin history is lost.
- Release of rst_n takes effect at the first rising clk edge with rst_n high.
- Latency: req sampled nonzero at edge k while IDLE → out_valid high after edge k (visible in cycle k+1). One cycle, fully registered, with no combinational path from req to outputs.
- All outputs are registered. out_ready affects only the next-state logic, never outputs in the same cycle.
- Throughput: one grant per cycle while out_ready stays high and v ≠ 0.

## Test plan
- Reset and idle:
  - Assert rst_n = 0 mid-HOLD → out_valid, out_idx and out_onehot all go to 0 immediately, before any clk edge.
  - After release with req = 0 for 5 cycles → out_valid stays 0.
- Fixed encode, N = 10:
  - req = 234 (0b0011101010) → next cycle out_valid = 1, out_idx = 7, out_onehot = 0x080.
  - Then req = 512, 256, …, 1 one at a time, each accepted → out_idx = 9, 8, …, 0.
- Sticky hold:
  - req = 3, out_ready = 0 → out_idx = 1.
  - Change req to 1000, then to 0, for 4 cycles → out_idx stays 1 and out_onehot stays 0x002.
  - Then out_ready = 1 with req = 0 → IDLE next cycle.
- Fixed back-to-back: req = 1023, out_ready held at 1 → out_idx sequence 9, 8, 9, 8 …, with out_valid continuously 1.
- Round-robin (ROUND_ROBIN = 1): req = 1023, out_ready = 1 → out_idx sequence 9, 8, 7, …, 0, 9 (wrap).
- Round-robin fairness with req = 340 (0b0101010100), always ready:
  - out_idx cycles 8, 6, 4, 2, 8.
  - Drop bit 6 mid-sequence → bit 6 is skipped on the next pass.

Source files
------------

// File: rtl/priority_grant_encoder.sv
// -----------------------------------------------------------------------------
// priority_grant_encoder
//
// Registered priority encoder with a valid/ready output handshake. It picks
// one winner from N request lines, presents its binary index and one-hot
// grant, and holds that grant until the downstream dispatcher accepts it.
// With ROUND_ROBIN = 1 the search start rotates past each accepted winner,
// so every active requester is served in turn. With ROUND_ROBIN = 0 the
// highest set index always wins.
//
// Parameters:
//   N            number of request lines (N >= 2)
//   IDX_W        width of out_idx (2**IDX_W >= N)
//   ROUND_ROBIN  0 = fixed priority, 1 = rotating priority
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   req          in   N      request vector, bit i = requester i
//   out_valid    out  1      a winner is being presented (registered)
//   out_ready    in   1      downstream accepts the presented winner
//   out_idx      out  IDX_W  binary index of the winner (registered)
//   out_onehot   out  N      one-hot grant, zero when idle (registered)
// -----------------------------------------------------------------------------
module priority_grant_encoder #(
   parameter int N           = 10,
   parameter int IDX_W       = 4,
   parameter int ROUND_ROBIN = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic [N-1:0]     out_onehot
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   localparam logic [IDX_W-1:0] PTR_MAX    = IDX_W'(N - 1);
   localparam logic [IDX_W-1:0] IDX_ONE    = {{(IDX_W-1){1'b0}}, 1'b1};
   localparam logic [N-1:0]     ONEHOT_ONE = {{(N-1){1'b0}}, 1'b1};

   state_t           state_r;
   state_t           state_s;
   logic [IDX_W-1:0] ptr_r;
   logic [IDX_W-1:0] ptr_s;
   logic [IDX_W-1:0] idx_s;
   logic [N-1:0]     onehot_s;
   logic             valid_s;
   logic [N-1:0]     search_s;

   // Search order is start, start-1, ..., 0, N-1, ..., start+1; the first set
   // bit wins. start is always in 0..N-1, so a nonzero vec always yields an
   // index below N.
   function automatic logic [IDX_W-1:0] pick_winner(
      input logic [N-1:0]     vec,
      input logic [IDX_W-1:0] start
   );
      logic [IDX_W-1:0] win;
      logic             found;
      logic [N-1:0]     shifted;
      logic             hit;
      int               pos;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         pos     = (int'(start) >= k) ? (int'(start) - k) : (int'(start) + N - k);
         shifted = vec >> pos;
         hit     = ~found & shifted[0];
         win     = hit ? IDX_W'(pos) : win;
         found   = found | shifted[0];
      end
      return win;
   endfunction

   // Expand a binary index into the matching one-hot grant vector.
   function automatic logic [N-1:0] onehot_of(input logic [IDX_W-1:0] idx);
      return ONEHOT_ONE << idx;
   endfunction

   // Next-state and next-output logic; everything defaults to holding.
   always_comb begin
      state_s  = state_r;
      ptr_s    = ptr_r;
      idx_s    = out_idx;
      onehot_s = out_onehot;
      valid_s  = out_valid;
      search_s = '0;
      case (state_r)
         ST_IDLE: begin
            // out_ready is deliberately ignored here.
            if (|req) begin
               idx_s    = pick_winner(req, ptr_r);
               onehot_s = onehot_of(idx_s);
               valid_s  = 1'b1;
               state_s  = ST_HOLD;
            end else begin
               valid_s  = 1'b0;
               onehot_s = '0;
               state_s  = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               // Rotate the pointer past the accepted winner before the next
               // search, so the new winner is chosen with the updated start.
               if (ROUND_ROBIN != 0) begin
                  ptr_s = (out_idx == '0) ? PTR_MAX : (out_idx - IDX_ONE);
               end else begin
                  ptr_s = PTR_MAX;
               end
               // The just-accepted requester is masked for this cycle only,
               // which is what lets fixed priority alternate between the top
               // two requesters instead of starving everyone else.
               search_s = req & ~out_onehot;
               if (|search_s) begin
                  idx_s    = pick_winner(search_s, ptr_s);
                  onehot_s = onehot_of(idx_s);
                  valid_s  = 1'b1;
                  state_s  = ST_HOLD;
               end else begin
                  // out_idx keeps its last value on the way back to idle.
                  valid_s  = 1'b0;
                  onehot_s = '0;
                  state_s  = ST_IDLE;
               end
            end else begin
               // Sticky grant: nothing moves until the winner is accepted.
               state_s = ST_HOLD;
            end
         end
         default: begin
            state_s  = ST_IDLE;
            ptr_s    = PTR_MAX;
            valid_s  = 1'b0;
            onehot_s = '0;
            idx_s    = '0;
         end
      endcase
   end

   // State, pointer and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         ptr_r      <= PTR_MAX;
         out_valid  <= 1'b0;
         out_idx    <= '0;
         out_onehot <= '0;
      end else begin
         state_r    <= state_s;
         ptr_r      <= ptr_s;
         out_valid  <= valid_s;
         out_idx    <= idx_s;
         out_onehot <= onehot_s;
      end
   end

endmodule

// File: tb/tb_priority_grant_encoder.sv
// -----------------------------------------------------------------------------
// tb_priority_grant_encoder
//
// Directed bench for priority_grant_encoder. One instance runs in fixed
// priority mode, a second in round-robin mode; both share clock and reset.
// Inputs change 1 time unit after a rising edge and outputs are checked at
// that same point, i.e. they reflect the state loaded by that edge.
// -----------------------------------------------------------------------------
module tb_priority_grant_encoder;

   localparam int N     = 10;
   localparam int IDX_W = 4;

   logic             clk;
   logic             rst_n;

   logic [N-1:0]     req_f;
   logic             rdy_f;
   logic             valid_f;
   logic [IDX_W-1:0] idx_f;
   logic [N-1:0]     oh_f;

   logic [N-1:0]     req_r;
   logic             rdy_r;
   logic             valid_r;
   logic [IDX_W-1:0] idx_r;
   logic [N-1:0]     oh_r;

   int errors;
   int checks;

   priority_grant_encoder #(.N(N), .IDX_W(IDX_W), .ROUND_ROBIN(0)) dut_fixed (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req_f),
      .out_valid  (valid_f),
      .out_ready  (rdy_f),
      .out_idx    (idx_f),
      .out_onehot (oh_f)
   );

   priority_grant_encoder #(.N(N), .IDX_W(IDX_W), .ROUND_ROBIN(1)) dut_rr (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req_r),
      .out_valid  (valid_r),
      .out_ready  (rdy_r),
      .out_idx    (idx_r),
      .out_onehot (oh_r)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_fixed(input string tag, input logic v, input int idx, input logic [N-1:0] oh);
      check_eq({tag, ".valid"},  32'(valid_f), 32'(v));
      check_eq({tag, ".idx"},    32'(idx_f),   32'(idx));
      check_eq({tag, ".onehot"}, 32'(oh_f),    32'(oh));
   endtask

   task automatic check_rr(input string tag, input int idx);
      check_eq({tag, ".valid"},  32'(valid_r), 32'd1);
      check_eq({tag, ".idx"},    32'(idx_r),   32'(idx));
      check_eq({tag, ".onehot"}, 32'(oh_r),    32'd1 << idx);
   endtask

   initial begin
      int rr_seq[4];
      errors = 0;
      checks = 0;
      req_f  = '0;
      rdy_f  = 1'b0;
      req_r  = '0;
      rdy_r  = 1'b0;
      rst_n  = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check_fixed("reset", 1'b0, 0, 10'h000);
      check_eq("reset.rr_valid", 32'(valid_r), 32'd0);
      #10 rst_n = 1'b1;

      // Idle with no requests for 5 cycles.
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("idle.valid", 32'(valid_f), 32'd0);
      end

      // Fixed encode: 0b0011101010 -> highest set bit is 7.
      req_f = 10'd234;
      tick();
      check_fixed("enc234", 1'b1, 7, 10'h080);

      // Single requests, each accepting the previous winner.
      rdy_f = 1'b1;
      for (int i = 9; i >= 0; i--) begin
         req_f = 10'd1 << i;
         tick();
         check_fixed("single", 1'b1, i, 10'd1 << i);
      end
      req_f = '0;
      tick();
      check_fixed("single_done", 1'b0, 0, 10'h000);

      // Sticky hold: grant 1 survives request changes while not ready.
      rdy_f = 1'b0;
      req_f = 10'd3;
      tick();
      check_fixed("sticky_grant", 1'b1, 1, 10'h002);
      req_f = 10'd1000;
      tick();
      check_fixed("sticky_1000a", 1'b1, 1, 10'h002);
      tick();
      check_fixed("sticky_1000b", 1'b1, 1, 10'h002);
      req_f = 10'd0;
      tick();
      check_fixed("sticky_zero_a", 1'b1, 1, 10'h002);
      tick();
      check_fixed("sticky_zero_b", 1'b1, 1, 10'h002);
      rdy_f = 1'b1;
      tick();
      check_fixed("sticky_release", 1'b0, 1, 10'h000);
      tick();
      check_fixed("idle_ready_ignored", 1'b0, 1, 10'h000);

      // Fixed back-to-back with every request set: 9, 8, 9, 8.
      req_f = 10'd1023;
      tick();
      check_fixed("b2b0", 1'b1, 9, 10'h200);
      tick();
      check_fixed("b2b1", 1'b1, 8, 10'h100);
      tick();
      check_fixed("b2b2", 1'b1, 9, 10'h200);
      tick();
      check_fixed("b2b3", 1'b1, 8, 10'h100);
      req_f = 10'd0;
      tick();
      check_fixed("b2b_end", 1'b0, 8, 10'h000);

      // Reset in the middle of a held grant clears outputs without a clock.
      rdy_f = 1'b0;
      req_f = 10'd3;
      tick();
      check_fixed("pre_reset", 1'b1, 1, 10'h002);
      #2 rst_n = 1'b0;
      #1;
      check_fixed("async_reset", 1'b0, 0, 10'h000);
      req_f = 10'd0;
      tick();
      #2 rst_n = 1'b1;
      tick();
      check_fixed("post_reset", 1'b0, 0, 10'h000);

      // Round-robin with all requests: 9 down to 0, then wrap to 9.
      req_r = 10'd1023;
      rdy_r = 1'b1;
      for (int i = 9; i >= 0; i--) begin
         tick();
         check_rr("rr_all", i);
      end
      tick();
      check_rr("rr_wrap", 9);
      req_r = 10'd0;
      tick();
      check_eq("rr_all_end.valid", 32'(valid_r), 32'd0);

      // Fairness over 0b0101010100: 8, 6, 4, 2, 8.
      req_r  = 10'd340;
      rr_seq = '{8, 6, 4, 2};
      for (int i = 0; i < 4; i++) begin
         tick();
         check_rr("rr_fair", rr_seq[i]);
      end
      tick();
      check_rr("rr_fair_wrap", 8);

      // Drop bit 6: the next pass goes 4, 2, 8.
      req_r  = 10'd340 & ~10'd64;
      rr_seq = '{4, 2, 8, 0};
      for (int i = 0; i < 3; i++) begin
         tick();
         check_rr("rr_skip6", rr_seq[i]);
      end
      req_r = 10'd0;
      tick();
      check_eq("rr_fair_end.valid", 32'(valid_r), 32'd0);
      check_eq("rr_fair_end.onehot", 32'(oh_r), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
